// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, state encoding and ID constants
// used by apb_slave and by apb_master benches.
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
    localparam logic [APB_DATA_W-1:0] APB_SLAVE_ID = 8'hA5;
    localparam logic [APB_ADDR_W-1:0] ID_ADDR = 8'hFF;
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_e;
endpackage

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: NUM_REGS read/write byte registers plus the read-only ID
// register at ID_ADDR, with write enable and combinational read mux.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  we,
    input  logic [APB_ADDR_W-1:0] addr,
    input  logic [APB_DATA_W-1:0] wdata,
    output logic [APB_DATA_W-1:0] rdata
);
    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
    logic [APB_DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        rdata  = (addr == ID_ADDR) ? APB_SLAVE_ID : '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we && addr == APB_ADDR_W'(i)) regs_d[i] = wdata;
            if (addr == APB_ADDR_W'(i)) rdata = regs_q[i];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) regs_q <= '{default: '0};
        else          regs_q <= regs_d;
    end
endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB slave with register bank, error decode and read-only ID register.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states per access.
module apb_slave
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);
    apb_state_e            state_q, state_d;
    logic [APB_ADDR_W-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  setup, complete, err, wait_done;
    logic [APB_DATA_W-1:0] rdata;

    assign setup = psel && !penable;

`ifdef APB_SLAVE_WAIT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    assign wait_done = (wait_cnt_q == '0);
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE && setup) wait_cnt_d = 8'(WAIT_CYCLES);
        else if (state_q == ACCESS && psel && penable && !wait_done) wait_cnt_d = wait_cnt_q - 8'd1;
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) wait_cnt_q <= '0;
        else          wait_cnt_q <= wait_cnt_d;
    end
`else
    logic unused_wait_cycles;
    assign unused_wait_cycles = (WAIT_CYCLES != 0);
    assign wait_done = 1'b1;
`endif

    // pready depends only on registered state and psel
    assign pready   = (state_q == ACCESS) && psel && wait_done;
    assign complete = pready && penable;
    assign err      = (addr_q == ID_ADDR) ? write_q : (addr_q >= APB_ADDR_W'(NUM_REGS));
    assign pslverr  = pready && err;
    assign prdata   = (pready && !write_q && !err) ? rdata : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        if (state_q == IDLE) begin
            if (setup) begin
                state_d = ACCESS;
                addr_d  = paddr;
                write_d = pwrite;
            end
        end else if (!psel || complete) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    apb_slave_regbank #(.NUM_REGS(NUM_REGS)) u_regbank (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (complete && write_q && !err),
        .addr    (addr_q),
        .wdata   (pwdata),
        .rdata   (rdata)
    );
endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed APB transfers; expected responses queued by the driver
// and checked by a monitor whenever the slave completes a transfer.
module tb_apb_slave;
    import apb_pkg::*;

`ifdef APB_SLAVE_WAIT_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         len;
    } exp_t;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    apb_slave #(.NUM_REGS(16), .WAIT_CYCLES(2)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic e, input logic [7:0] r);
        bit done;
        exp_q.push_back('{e, r, 2 + WS});
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1 penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            done = pready;
            @(posedge pclk); #1;
        end
        if (!done) chk("xfer_timeout", 0, 1);
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    always @(negedge pclk) begin
        if (presetn && psel) begin
            cyc = penable ? cyc + 1 : 1;
            if (penable && pready) begin
                if (exp_q.size() == 0) chk("unexpected_ready", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("pslverr", int'(pslverr), int'(mon_e.err));
                    chk("prdata", int'(prdata), int'(mon_e.rdata));
                    chk("ready_cycle", cyc, mon_e.len);
                end
            end else begin
                chk("wait_prdata", int'(prdata), 0);
                chk("wait_pslverr", int'(pslverr), 0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_pready", int'(pready), 0);
        chk("rst_prdata", int'(prdata), 0);
        chk("rst_pslverr", int'(pslverr), 0);
        presetn = 1'b1;
        idle();
        // write then read
        xfer(1'b1, 8'h05, 8'h3C, 1'b0, 8'h00);
        idle();
        xfer(1'b0, 8'h05, 8'h00, 1'b0, 8'h3C);
        idle();
        // error decode and ID register
        xfer(1'b0, 8'h20, 8'h00, 1'b1, 8'h00);
        xfer(1'b1, 8'hFF, 8'h11, 1'b1, 8'h00);
        xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5);
        xfer(1'b1, 8'h0F, 8'h5A, 1'b0, 8'h00);
        xfer(1'b1, 8'h10, 8'h66, 1'b1, 8'h00);
        xfer(1'b0, 8'h0F, 8'h00, 1'b0, 8'h5A);
        xfer(1'b0, 8'h10, 8'h00, 1'b1, 8'h00);
        idle();
        // aborted write: psel dropped right after setup
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h77;
        @(posedge pclk); #1 psel = 1'b0;
        @(negedge pclk);
        chk("abort_pready", int'(pready), 0);
        @(posedge pclk); #1;
        idle();
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 8'h00);
        // back-to-back writes and reads
        xfer(1'b1, 8'h00, 8'h01, 1'b0, 8'h00);
        xfer(1'b1, 8'h01, 8'h02, 1'b0, 8'h00);
        xfer(1'b1, 8'h02, 8'h03, 1'b0, 8'h00);
        xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h01);
        xfer(1'b0, 8'h01, 8'h00, 1'b0, 8'h02);
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 8'h03);
        idle();
        // reset pulse during the access phase of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'hAA;
        @(posedge pclk); #1 penable = 1'b1;
        #2 presetn = 1'b0;
        #1;
        chk("rstmid_pready", int'(pready), 0);
        chk("rstmid_prdata", int'(prdata), 0);
        chk("rstmid_pslverr", int'(pslverr), 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        idle();
        xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00);
        xfer(1'b0, 8'h05, 8'h00, 1'b0, 8'h00);
        xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5);
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
